// File: rtl/rriot_pkg.sv
//==============================================================================
// Module  : rriot_pkg
// Brief   : Shared types and address map for the RRIOT bus arbiter.
// Rev     : 1.0 - initial release
//==============================================================================
`default_nettype none

package rriot_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        T_RAM  = 2'd0,
        T_IO   = 2'd1,
        T_TMR  = 2'd2,
        T_NONE = 2'd3
    } target_t;

    // RAM starts at address zero, so only its upper limit is needed.
    localparam int unsigned RAM_LIMIT = 32'h3F;
    localparam int unsigned IO_BASE   = 32'h40;
    localparam int unsigned IO_LIMIT  = 32'h47;
    localparam int unsigned TMR_BASE  = 32'h48;
    localparam int unsigned TMR_LIMIT = 32'h4F;

    localparam logic [7:0] UNMAPPED_DATA_DEF = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/rriot_bus_arb_if.sv
//==============================================================================
// Module  : rriot_bus_arb_if
// Brief   : Requester handshake bundle; err is present with RRIOT_ARB_ERR_EN.
// Rev     : 1.0 - initial release
//==============================================================================
`default_nettype none

interface rriot_bus_arb_if #(
    parameter int AW = 7
);
    logic          req;
    logic          we_n;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    logic          done;
    logic [7:0]    rdata;
`ifdef RRIOT_ARB_ERR_EN
    logic          err;

    modport master (output req, we_n, addr, wdata, input  done, rdata, err);
    modport slave  (input  req, we_n, addr, wdata, output done, rdata, err);
`else
    modport master (output req, we_n, addr, wdata, input  done, rdata);
    modport slave  (input  req, we_n, addr, wdata, output done, rdata);
`endif
endinterface

`default_nettype wire

// File: rtl/rriot_addr_dec.sv
//==============================================================================
// Module  : rriot_addr_dec
// Brief   : Combinational RRIOT address to target decode.
// Rev     : 1.0 - initial release
//==============================================================================
`default_nettype none

module rriot_addr_dec
    import rriot_pkg::*;
#(
    parameter int AW = 7
) (
    input  wire logic [AW-1:0] addr,
    output target_t            target
);

    logic [31:0] addr_ext;

    always_comb begin
        addr_ext = {{(32-AW){1'b0}}, addr};
        target   = T_NONE;
        if (addr_ext <= RAM_LIMIT) begin
            target = T_RAM;
        end else if (addr_ext >= IO_BASE && addr_ext <= IO_LIMIT) begin
            target = T_IO;
        end else if (addr_ext >= TMR_BASE && addr_ext <= TMR_LIMIT) begin
            target = T_TMR;
        end
    end

endmodule

`default_nettype wire

// File: rtl/rriot_bus_arb.sv
//==============================================================================
// Module  : rriot_bus_arb
// Brief   : Two-requester sequencer/arbiter for RRIOT I/O, timer and RAM.
//           Optional error reporting enabled by RRIOT_ARB_ERR_EN.
// Rev     : 1.0 - initial release
//==============================================================================
`default_nettype none

module rriot_bus_arb
    import rriot_pkg::*;
#(
    parameter int         AW            = 7,
    parameter int         STARVE_MAX    = 4,
    parameter logic [7:0] UNMAPPED_DATA = UNMAPPED_DATA_DEF
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    rriot_bus_arb_if.slave     cpu,
    rriot_bus_arb_if.slave     dbg,
    output logic               t_we_n,
    output logic [AW-1:0]      t_addr,
    output logic [7:0]         t_wdata,
    output logic               io_enable,
    output logic               tmr_enable,
    output logic               ram_enable,
    input  wire logic          io_oe,
    input  wire logic          tmr_oe,
    input  wire logic          ram_oe,
    input  wire logic [7:0]    io_do,
    input  wire logic [7:0]    tmr_do,
    input  wire logic [7:0]    ram_do
);

    arb_state_t  state, state_nxt;
    target_t     target;
    logic        owner_dbg;
    logic [3:0]  starve_cnt;
    logic        starve_hit;
    logic        grant_cpu, grant_dbg;
    logic        sel_oe;
    logic [7:0]  sel_do;
    logic [7:0]  cap_data;
    logic        cpu_done_c, dbg_done_c;
    logic [7:0]  cpu_rdata_r, dbg_rdata_r;

    rriot_addr_dec #(.AW(AW)) u_dec (
        .addr   (t_addr),
        .target (target)
    );

    assign starve_hit = (starve_cnt == 4'(STARVE_MAX));

    always_comb begin
        grant_dbg = dbg.req && (!cpu.req || starve_hit);
        grant_cpu = cpu.req && !grant_dbg;
    end

    always_comb begin
        sel_oe = 1'b0;
        sel_do = UNMAPPED_DATA;
        case (target)
            T_RAM:   begin sel_oe = ram_oe; sel_do = ram_do; end
            T_IO:    begin sel_oe = io_oe;  sel_do = io_do;  end
            T_TMR:   begin sel_oe = tmr_oe; sel_do = tmr_do; end
            default: begin sel_oe = 1'b0;   sel_do = UNMAPPED_DATA; end
        endcase
        cap_data = sel_oe ? sel_do : UNMAPPED_DATA;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        io_enable  = 1'b0;
        tmr_enable = 1'b0;
        ram_enable = 1'b0;
        cpu_done_c = 1'b0;
        dbg_done_c = 1'b0;
        case (state)
            IDLE: begin
                if (cpu.req || dbg.req) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                io_enable  = (target == T_IO);
                tmr_enable = (target == T_TMR);
                ram_enable = (target == T_RAM);
                state_nxt  = WAIT;
            end
            WAIT: begin
                state_nxt = RESP;
            end
            RESP: begin
                cpu_done_c = !owner_dbg;
                dbg_done_c = owner_dbg;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_we_n      <= 1'b1;
            t_addr      <= '0;
            t_wdata     <= 8'h00;
            owner_dbg   <= 1'b0;
            starve_cnt  <= 4'd0;
            cpu_rdata_r <= 8'h00;
            dbg_rdata_r <= 8'h00;
        end else begin
            if (state == IDLE && (grant_cpu || grant_dbg)) begin
                owner_dbg <= grant_dbg;
                t_we_n    <= grant_dbg ? dbg.we_n  : cpu.we_n;
                t_addr    <= grant_dbg ? dbg.addr  : cpu.addr;
                t_wdata   <= grant_dbg ? dbg.wdata : cpu.wdata;
            end

            // Counter tracks only CPU wins that actually held debug off.
            if (!dbg.req) begin
                starve_cnt <= 4'd0;
            end else if (state == IDLE && grant_dbg) begin
                starve_cnt <= 4'd0;
            end else if (state == IDLE && grant_cpu && !starve_hit) begin
                starve_cnt <= starve_cnt + 4'd1;
            end

            if (state == WAIT && t_we_n) begin
                if (owner_dbg) begin
                    dbg_rdata_r <= cap_data;
                end else begin
                    cpu_rdata_r <= cap_data;
                end
            end
        end
    end

    assign cpu.done  = cpu_done_c;
    assign dbg.done  = dbg_done_c;
    assign cpu.rdata = cpu_rdata_r;
    assign dbg.rdata = dbg_rdata_r;

`ifdef RRIOT_ARB_ERR_EN
    logic cpu_err_r, dbg_err_r;
    logic err_c;

    assign err_c = (target == T_NONE) || (t_we_n && !sel_oe);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_err_r <= 1'b0;
            dbg_err_r <= 1'b0;
        end else if (state == WAIT) begin
            if (owner_dbg) begin
                dbg_err_r <= err_c;
            end else begin
                cpu_err_r <= err_c;
            end
        end
    end

    assign cpu.err = cpu_err_r;
    assign dbg.err = dbg_err_r;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rriot_bus_arb.sv
//==============================================================================
// Module  : tb_rriot_bus_arb
// Brief   : Directed self-checking bench for rriot_bus_arb.
// Rev     : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rriot_bus_arb;

    logic       clk;
    logic       rst_n;
    logic       t_we_n;
    logic [6:0] t_addr;
    logic [7:0] t_wdata;
    logic       io_enable, tmr_enable, ram_enable;
    logic       io_oe, tmr_oe, ram_oe;
    logic [7:0] io_do, tmr_do, ram_do;

    logic [7:0] ram_mem [64];
    logic [7:0] io_regs [4];

    int vectors;
    int miscompares;

    rriot_bus_arb_if #(.AW(7)) cpu_if ();
    rriot_bus_arb_if #(.AW(7)) dbg_if ();

    rriot_bus_arb #(.AW(7), .STARVE_MAX(4), .UNMAPPED_DATA(8'hFF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu        (cpu_if),
        .dbg        (dbg_if),
        .t_we_n     (t_we_n),
        .t_addr     (t_addr),
        .t_wdata    (t_wdata),
        .io_enable  (io_enable),
        .tmr_enable (tmr_enable),
        .ram_enable (ram_enable),
        .io_oe      (io_oe),
        .tmr_oe     (tmr_oe),
        .ram_oe     (ram_oe),
        .io_do      (io_do),
        .tmr_do     (tmr_do),
        .ram_do     (ram_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Target models: registered OE/DO one cycle after enable.
    // IO offsets 0-3 are registers; 4-7 never drive OE.
    always @(posedge clk) begin
        ram_oe  <= ram_enable && t_we_n;
        ram_do  <= ram_mem[t_addr[5:0]];
        if (ram_enable && !t_we_n) ram_mem[t_addr[5:0]] <= t_wdata;
        io_oe   <= io_enable && t_we_n && !t_addr[2];
        io_do   <= io_regs[t_addr[1:0]];
        if (io_enable && !t_we_n && !t_addr[2]) io_regs[t_addr[1:0]] <= t_wdata;
        tmr_oe  <= tmr_enable && t_we_n;
        tmr_do  <= 8'h3C;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete transaction from IDLE; checks every phase.
    task automatic do_txn(input bit use_dbg, input bit we_n, input logic [6:0] addr,
                          input logic [7:0] wd, input logic [2:0] exp_en,
                          input logic [7:0] exp_rd, input bit exp_err, input string tag);
        if (use_dbg) begin
            dbg_if.req = 1'b1; dbg_if.we_n = we_n; dbg_if.addr = addr; dbg_if.wdata = wd;
        end else begin
            cpu_if.req = 1'b1; cpu_if.we_n = we_n; cpu_if.addr = addr; cpu_if.wdata = wd;
        end
        tick;
        chk({tag, " issue_en"}, {29'd0, ram_enable, tmr_enable, io_enable}, {29'd0, exp_en});
        chk({tag, " t_we_n"}, {31'd0, t_we_n}, {31'd0, we_n});
        chk({tag, " t_addr"}, {25'd0, t_addr}, {25'd0, addr});
        if (!we_n) chk({tag, " t_wdata"}, {24'd0, t_wdata}, {24'd0, wd});
        tick;
        chk({tag, " wait_en"}, {29'd0, ram_enable, tmr_enable, io_enable}, 32'd0);
        chk({tag, " wait_done"}, {30'd0, cpu_if.done, dbg_if.done}, 32'd0);
        tick;
        chk({tag, " resp_done"}, {30'd0, cpu_if.done, dbg_if.done},
            use_dbg ? 32'd1 : 32'd2);
        chk({tag, " rdata"}, {24'd0, use_dbg ? dbg_if.rdata : cpu_if.rdata}, {24'd0, exp_rd});
`ifdef RRIOT_ARB_ERR_EN
        chk({tag, " err"}, {31'd0, use_dbg ? dbg_if.err : cpu_if.err}, {31'd0, exp_err});
`else
        if (exp_err) begin end
`endif
        if (use_dbg) dbg_if.req = 1'b0; else cpu_if.req = 1'b0;
        tick;
        chk({tag, " idle_done"}, {30'd0, cpu_if.done, dbg_if.done}, 32'd0);
    endtask

    initial begin
        logic [5:0] exp_dbg_win;
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 64; i++) ram_mem[i] = 8'(i) ^ 8'hA5;
        for (int i = 0; i < 4; i++) io_regs[i] = 8'h00;
        cpu_if.req = 1'b0; cpu_if.we_n = 1'b1; cpu_if.addr = 7'h00; cpu_if.wdata = 8'h00;
        dbg_if.req = 1'b0; dbg_if.we_n = 1'b1; dbg_if.addr = 7'h00; dbg_if.wdata = 8'h00;
        rst_n = 1'b0;
        tick;
        tick;
        chk("rst enables", {29'd0, ram_enable, tmr_enable, io_enable}, 32'd0);
        chk("rst t_we_n", {31'd0, t_we_n}, 32'd1);
        chk("rst t_addr", {25'd0, t_addr}, 32'd0);
        chk("rst t_wdata", {24'd0, t_wdata}, 32'd0);
        chk("rst done", {30'd0, cpu_if.done, dbg_if.done}, 32'd0);
        chk("rst rdata", {16'd0, cpu_if.rdata, dbg_if.rdata}, 32'd0);
        rst_n = 1'b1;
        tick;

        do_txn(1'b0, 1'b0, 7'h41, 8'h5A, 3'b001, 8'h00, 1'b0, "cpu_wr_ddra");
        do_txn(1'b0, 1'b1, 7'h41, 8'h00, 3'b001, 8'h5A, 1'b0, "cpu_rd_ddra");
        do_txn(1'b0, 1'b1, 7'h44, 8'h00, 3'b001, 8'hFF, 1'b1, "cpu_rd_io_noe");
        do_txn(1'b0, 1'b0, 7'h60, 8'h11, 3'b000, 8'hFF, 1'b1, "cpu_wr_unmap");
        do_txn(1'b0, 1'b1, 7'h4A, 8'h00, 3'b010, 8'h3C, 1'b0, "cpu_rd_tmr");
        do_txn(1'b1, 1'b1, 7'h3F, 8'h00, 3'b100, 8'h9A, 1'b0, "dbg_rd_ram3f");
        do_txn(1'b0, 1'b1, 7'h7F, 8'h00, 3'b000, 8'hFF, 1'b1, "cpu_rd_unmap");

        // Starvation: both held high, debug forced after four CPU grants.
        exp_dbg_win = 6'b010000;
        cpu_if.req = 1'b1; cpu_if.we_n = 1'b1; cpu_if.addr = 7'h10;
        dbg_if.req = 1'b1; dbg_if.we_n = 1'b1; dbg_if.addr = 7'h20;
        for (int i = 0; i < 6; i++) begin
            tick;
            tick;
            tick;
            chk($sformatf("starve done %0d", i), {30'd0, cpu_if.done, dbg_if.done},
                exp_dbg_win[i] ? 32'd1 : 32'd2);
            chk($sformatf("starve rdata %0d", i),
                {24'd0, exp_dbg_win[i] ? dbg_if.rdata : cpu_if.rdata},
                exp_dbg_win[i] ? 32'h85 : 32'hB5);
            if (i == 5) begin
                cpu_if.req = 1'b0;
                dbg_if.req = 1'b0;
            end
            tick;
        end
        chk("starve idle", {30'd0, cpu_if.done, dbg_if.done}, 32'd0);

        // Reset in WAIT of a RAM read.
        cpu_if.req = 1'b1; cpu_if.we_n = 1'b1; cpu_if.addr = 7'h05;
        tick;
        chk("rstmid issue ram_en", {31'd0, ram_enable}, 32'd1);
        tick;
        rst_n = 1'b0;
        #1;
        chk("rstmid enables", {29'd0, ram_enable, tmr_enable, io_enable}, 32'd0);
        chk("rstmid t_we_n", {31'd0, t_we_n}, 32'd1);
        chk("rstmid t_addr", {25'd0, t_addr}, 32'd0);
        chk("rstmid rdata", {16'd0, cpu_if.rdata, dbg_if.rdata}, 32'd0);
        chk("rstmid done", {30'd0, cpu_if.done, dbg_if.done}, 32'd0);
        cpu_if.req = 1'b0;
        tick;
        tick;
        chk("rstmid no done", {30'd0, cpu_if.done, dbg_if.done}, 32'd0);
        rst_n = 1'b1;
        tick;
        do_txn(1'b0, 1'b1, 7'h05, 8'h00, 3'b100, 8'hA0, 1'b0, "post_rst_rd");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rriot_bus_arb.md
Name: rriot_bus_arb

Overview:
- Sequencer and arbiter for the RRIOT register space: the I/O port block, the interval timer and the 64-byte RAM.
- Two requesters share these resources: the CPU bus side and the debug/config loader.
- Decodes the address, issues one-cycle target enable pulses and captures the registered OE/DO return one cycle later.
- Returns a done pulse and read data to the winning requester.

Parameters:
- AW, 7, requester/target address width.
- STARVE_MAX, 4, consecutive CPU grants allowed while dbg_req is pending before debug is forced; range 1..15.
- UNMAPPED_DATA, 8'hFF, read data returned for unmapped addresses or when no OE is seen.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU request, held until cpu_done.
- cpu_we_n  in  1  0=write, 1=read.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_rdata  out  8  read data, valid with cpu_done.
- dbg_req, dbg_we_n, dbg_addr, dbg_wdata, dbg_done, dbg_rdata  same shape as the cpu_* ports, debug requester.
- t_we_n  out  1  target write strobe polarity.
- t_addr  out  AW  target address (the I/O block uses [2:0]).
- t_wdata  out  8  target write data.
- io_enable, tmr_enable, ram_enable  out  1 each  one-hot target enables.
- io_oe, tmr_oe, ram_oe  in  1 each  target read-valid.
- io_do, tmr_do, ram_do  in  8 each  target read data.

Behaviour:
- Reset (async, rst_n low): FSM=IDLE; all enables 0; t_we_n=1; t_addr=0; t_wdata=0; *_done=0; *_rdata=0; starve counter=0.
- Address decode on AW=7:
  - 0x00-0x3F → RAM.
  - 0x40-0x47 → IO.
  - 0x48-0x4F → TIMER.
  - Everything else is unmapped.
- FSM states IDLE → ISSUE → WAIT → RESP → IDLE. Every transaction is exactly 4 states.
- IDLE:
  - Samples requests; the winner's we_n/addr/wdata are latched into t_* at the edge.
  - The owner bit is recorded.
  - If neither req is high, stay in IDLE.
- ISSUE: exactly one decoded enable high for one cycle. An unmapped address raises no enable.
- WAIT:
  - Enables are 0.
  - Capture: if the selected target's oe=1, capture its do; else capture UNMAPPED_DATA.
  - Writes capture nothing and leave rdata unchanged.
- RESP:
  - The owner's done is high for one cycle, with rdata valid for reads.
  - The non-owner's done stays 0.
- Latency: req high at IDLE edge N → enable high in cycle N+1 → done in cycle N+3. Sustained throughput is 1 transaction per 4 cycles.
- Requester rule: req is deasserted at the edge ending its done cycle. The IDLE following RESP then sees the new req level.
- Arbitration:
  - CPU wins ties by fixed priority.
  - The starve counter increments on each CPU grant while dbg_req=1, and clears on any debug grant or when dbg_req=0.
  - When the counter equals STARVE_MAX and both requesters are pending, debug wins.
  - The counter saturates at STARVE_MAX.
- Request dropped mid-transaction: the transaction still completes and done still pulses. A write already enabled is not undone.
- Reset mid-transaction: immediate return to IDLE with no done pulse. A target write already strobed stands.
- t_addr/t_wdata/t_we_n hold their last values outside ISSUE. They are only meaningful with an enable.

Optional Feature:
- Macro: RRIOT_ARB_ERR_EN.
- Defined:
  - Adds ports cpu_err and dbg_err (out, 1 each), valid with done.
  - err=1 for an unmapped address (read or write), or for a read whose target gave oe=0 in WAIT. An example is IO offsets 4-7.
  - Reset value of err is 0.
- Undefined:
  - The ports are absent.
  - Such accesses complete silently, returning UNMAPPED_DATA on reads.

Decomposition:
- Package rriot_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - the target enum (T_RAM, T_IO, T_TMR, T_NONE);
  - address base/limit localparams;
  - UNMAPPED_DATA default.
- Natural sub-module rriot_addr_dec: combinational address → target enum. It is shared later by the CPU chip-select logic.

Test Plan:
- CPU write 0x41←8'h5A (DDRA), then read 0x41 → io_enable high cycle N+1 with t_we_n=0; read cpu_done at N+3, cpu_rdata=8'h5A.
- Simultaneous cpu_req and dbg_req re-asserted continuously with STARVE_MAX=4 → grant order CPU,CPU,CPU,CPU,DBG,CPU...; dbg_done after 4th cpu_done.
- Read 0x44 (IO default, OE=0) → cpu_rdata=8'hFF; with RRIOT_ARB_ERR_EN, cpu_err=1.
- Write 0x60 (unmapped) → no enable in ISSUE, cpu_done at N+3; with RRIOT_ARB_ERR_EN, cpu_err=1.
- rst_n low during WAIT of a RAM read → all outputs at reset values immediately; no cpu_done; next request is served normally from IDLE.
- Debug read of RAM 0x3F while cpu_req low → ram_enable one cycle, dbg_rdata=ram_do, cpu_done stays 0.
